// File: rtl/onewire_pkg.sv
// Shared types and standard-speed slot timing for the 1-Wire master PHY.
// Timing constants are in microseconds from the start of a slot.
package onewire_pkg;

    typedef enum logic [1:0] {
        CmdReset  = 2'd0,
        CmdWrite0 = 2'd1,
        CmdWrite1 = 2'd2,
        CmdRead   = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StRelease,
        StDone
    } state_e;

    localparam int unsigned UsW = 10;

    localparam logic [UsW-1:0] T_RSTL    = 10'd480;
    localparam logic [UsW-1:0] T_PDS     = 10'd550;
    localparam logic [UsW-1:0] T_RST_TOT = 10'd960;
    localparam logic [UsW-1:0] T_LOW0    = 10'd60;
    localparam logic [UsW-1:0] T_LOW1    = 10'd6;
    localparam logic [UsW-1:0] T_LOWR    = 10'd6;
    localparam logic [UsW-1:0] T_RDS     = 10'd15;
    localparam logic [UsW-1:0] T_SLOT    = 10'd70;

    typedef struct packed {
        logic [UsW-1:0] low;
        logic [UsW-1:0] sample;
        logic [UsW-1:0] total;
        logic           has_sample;
    } slot_timing_t;

    function automatic slot_timing_t slot_timing(input cmd_e c);
        slot_timing_t t;
        t.low        = T_LOWR;
        t.sample     = '0;
        t.total      = T_SLOT;
        t.has_sample = 1'b0;
        case (c)
            CmdReset: begin
                t.low        = T_RSTL;
                t.sample     = T_PDS;
                t.total      = T_RST_TOT;
                t.has_sample = 1'b1;
            end
            CmdWrite0: t.low = T_LOW0;
            CmdWrite1: t.low = T_LOW1;
            default: begin
                t.low        = T_LOWR;
                t.sample     = T_RDS;
                t.has_sample = 1'b1;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/onewire_us_tick.sv
// Microsecond prescaler: counts 0..CLK_MHZ-1 and emits a one-cycle tick on the
// last count. A synchronous clear holds it at zero and suppresses the tick.
module onewire_us_tick #(
    parameter int unsigned CLK_MHZ = 100
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PW-1:0] Last = PW'(CLK_MHZ - 1);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q;
        if (clr_i || presc_q == Last) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = !clr_i && (presc_q == Last);

endmodule

// File: rtl/onewire_phy.sv
// Standard-speed 1-Wire master PHY: one reset/write/read slot per accepted command.
// Define ONEWIRE_BUS_FAULT_EN to enable the end-of-slot stuck-low line check.
module onewire_phy
    import onewire_pkg::*;
#(
    parameter int unsigned CLK_MHZ = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic       rsp_bit,
    output logic       busy,
    output logic       bus_fault,
    inout  wire        din
);

    state_e         state_q, state_d;
    cmd_e           cmd_q, cmd_d;
    logic [UsW-1:0] us_cnt_q, us_cnt_d;
    logic           drive_low_q, drive_low_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_bit_q, rsp_bit_d;
    logic           busy_q, busy_d;
    logic           sync1_q, dq_s_q;

    logic           tick;
    logic           step;
    logic [UsW-1:0] us_next;
    logic           at_low, at_sample, at_total;
    slot_timing_t   tim;

`ifdef ONEWIRE_BUS_FAULT_EN
    logic           bus_fault_q, bus_fault_d;
`endif

    onewire_us_tick #(
        .CLK_MHZ(CLK_MHZ)
    ) u_us_tick (
        .clk_i  (clk),
        .reset_i(reset),
        .clr_i  (state_q == StIdle),
        .tick_o (tick)
    );

    assign tim     = slot_timing(cmd_q);
    assign step    = tick && (us_cnt_q != T_RST_TOT);
    assign us_next = us_cnt_q + 10'd1;

    // Each event fires exactly once: on the tick that moves us_cnt onto the target.
    assign at_low    = step && (us_next == tim.low);
    assign at_sample = step && (us_next == tim.sample) && tim.has_sample;
    assign at_total  = step && (us_next == tim.total);

    always_comb begin
        us_cnt_d = us_cnt_q;
        if (state_q == StIdle) begin
            if (cmd_valid) begin
                us_cnt_d = '0;
            end
        end else if (step) begin
            us_cnt_d = us_next;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        drive_low_d = drive_low_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_bit_d   = rsp_bit_q;
        busy_d      = busy_q;
`ifdef ONEWIRE_BUS_FAULT_EN
        bus_fault_d = bus_fault_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d     = StLow;
                    cmd_d       = cmd_e'(cmd);
                    drive_low_d = 1'b1;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            StLow: begin
                if (at_low) begin
                    state_d     = StRelease;
                    drive_low_d = 1'b0;
                end
            end
            StRelease: begin
                if (at_sample) begin
                    // Presence is an active-low response from the slave.
                    rsp_bit_d = (cmd_q == CmdReset) ? ~dq_s_q : dq_s_q;
                end
                if (at_total) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    if (cmd_q == CmdWrite0) begin
                        rsp_bit_d = 1'b0;
                    end else if (cmd_q == CmdWrite1) begin
                        rsp_bit_d = 1'b1;
                    end
`ifdef ONEWIRE_BUS_FAULT_EN
                    if (!dq_s_q) begin
                        bus_fault_d = 1'b1;
                        if (cmd_q == CmdReset) begin
                            rsp_bit_d = 1'b0;
                        end
                    end
`endif
                end
            end
            StDone: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_q       <= CmdReset;
            us_cnt_q    <= '0;
            drive_low_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            sync1_q     <= 1'b1;
            dq_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            us_cnt_q    <= us_cnt_d;
            drive_low_q <= drive_low_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            busy_q      <= busy_d;
            sync1_q     <= din;
            dq_s_q      <= sync1_q;
        end
    end

`ifdef ONEWIRE_BUS_FAULT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_fault_q <= 1'b0;
        end else begin
            bus_fault_q <= bus_fault_d;
        end
    end

    assign bus_fault = bus_fault_q;
`else
    assign bus_fault = 1'b0;
`endif

    // Open-drain: only ever pull low or release.
    assign din = drive_low_q ? 1'b0 : 1'bz;

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_onewire_phy.sv
// Bench for onewire_phy with a slot-level timing model and a simple slave on the line.
module tb_onewire_phy;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] cmd = 2'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_bit, busy, bus_fault;
    logic       slave_low = 1'b0;
    wire        din;

    pullup (din);
    assign din = slave_low ? 1'b0 : 1'bz;

    onewire_phy #(
        .CLK_MHZ(M)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid),
        .rsp_bit  (rsp_bit),
        .busy     (busy),
        .bus_fault(bus_fault),
        .din      (din)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: slot start edge, slot shape in microseconds, expected response.
    int edge_i = 0;
    bit m_active = 0;
    int m_t0 = 0;
    int m_low = 0;
    int m_total = 0;
    int m_bit = 0;
    int m_fault = 0;
    bit chk_en = 0;

    // Slave behaviour, in cycles relative to the slot start edge.
    int s_lo = 0;
    int s_hi = 0;
    bit s_stuck = 0;

    int last_acc = 0;

    function automatic int lv(input logic v);
        return (v === 1'b1) ? 1 : ((v === 1'b0) ? 0 : 2);
    endfunction

    function automatic bit pulled(input int n);
        return s_stuck || (n >= s_lo && n < s_hi);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_i);
        end
    endtask

    always @(posedge clk) begin : model_p
        int n;
        edge_i = edge_i + 1;
        if (reset) begin
            m_active = 0;
            m_fault  = 0;
        end else begin
            if (m_active && (edge_i - m_t0) > m_total * M + 1) m_active = 0;
`ifdef ONEWIRE_BUS_FAULT_EN
            if (m_active && (edge_i - m_t0) == m_total * M && pulled(m_total * M)) m_fault = 1;
`endif
            if (!m_active && cmd_valid) begin
                m_active = 1;
                m_t0 = edge_i;
                case (cmd)
                    2'd0: begin m_low = 480; m_total = 960; m_bit = pulled(550 * M) ? 1 : 0; end
                    2'd1: begin m_low = 60;  m_total = 70;  m_bit = 0; end
                    2'd2: begin m_low = 6;   m_total = 70;  m_bit = 1; end
                    default: begin m_low = 6; m_total = 70; m_bit = pulled(15 * M) ? 0 : 1; end
                endcase
`ifdef ONEWIRE_BUS_FAULT_EN
                if (cmd == 2'd0 && pulled(m_total * M)) m_bit = 0;
`endif
            end
        end
        #1;
        n = edge_i - m_t0;
        slave_low = s_stuck || (m_active && n >= s_lo && n < s_hi);
    end

    always @(negedge clk) begin : cmp_p
        int n;
        int e_busy, e_drive, e_rv;
        if (chk_en) begin
            n = edge_i - m_t0;
            e_busy  = (m_active && n <= m_total * M) ? 1 : 0;
            e_drive = (m_active && n < m_low * M) ? 1 : 0;
            e_rv    = (m_active && n == m_total * M) ? 1 : 0;
            chk("busy", lv(busy), e_busy);
            chk("cmd_ready", lv(cmd_ready), 1 - e_busy);
            chk("rsp_valid", lv(rsp_valid), e_rv);
            chk("din", lv(din), (e_drive == 1 || slave_low) ? 0 : 1);
            chk("bus_fault", lv(bus_fault), m_fault);
            if (e_rv == 1) chk("rsp_bit", lv(rsp_bit), m_bit);
        end
    end

    // Issue one slot and pin its shape with hand-computed literals (lit_low < 0 skips).
    task automatic do_slot(input logic [1:0] c, input bit hold, input int lit_rv,
                           input int lit_low, input int lit_bit);
        int k;
        int lows;
        int rv_at;
        @(negedge clk);
        cmd = c;
        cmd_valid = 1'b1;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", (k < 20000) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        last_acc = edge_i;
        if (!hold) cmd_valid = 1'b0;
        lows = 0;
        rv_at = -1;
        for (int i = 1; i <= lit_rv + 10 && rv_at < 0; i++) begin
            @(negedge clk);
            if (din === 1'b0 && !slave_low) lows++;
            if (rsp_valid === 1'b1) begin
                rv_at = i;
                chk("slot_rsp_bit", lv(rsp_bit), lit_bit);
            end
        end
        chk("slot_rv_cycle", rv_at, lit_rv);
        if (lit_low >= 0) chk("slot_low_cycles", lows, lit_low);
    endtask

    initial begin : watchdog_p
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim_p
        int acc1;
        int rv_cnt;
        int exp_bf;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", lv(cmd_ready), 1);
        chk("rst_rsp_valid", lv(rsp_valid), 0);
        chk("rst_rsp_bit", lv(rsp_bit), 0);
        chk("rst_busy", lv(busy), 0);
        chk("rst_bus_fault", lv(bus_fault), 0);
        chk("rst_din", lv(din), 1);
        chk_en = 1;

        // RESET with a slave answering 15..255 us after release.
        s_lo = 4800 + 150;
        s_hi = 4800 + 2550;
        do_slot(2'd0, 1'b0, 9601, 4800, 1);

        // RESET with no slave.
        s_lo = 0;
        s_hi = 0;
        do_slot(2'd0, 1'b0, 9601, 4800, 0);

        // WRITE0 then WRITE1 with cmd_valid held.
        do_slot(2'd1, 1'b1, 701, 600, 0);
        acc1 = last_acc;
        do_slot(2'd2, 1'b0, 701, 60, 1);
        chk("b2b_accept_gap", last_acc - acc1, 702);

        // READ: slave holds low 0..30 us, then idle line.
        s_lo = 0;
        s_hi = 300;
        do_slot(2'd3, 1'b0, 701, 0, 0);
        s_hi = 0;
        do_slot(2'd3, 1'b0, 701, 60, 1);

        // Reset 3000 cycles into a RESET slot.
        @(negedge clk);
        cmd = 2'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_din", lv(din), 1);
        chk("abort_cmd_ready", lv(cmd_ready), 1);
        chk("abort_busy", lv(busy), 0);
        chk("abort_rsp_bit", lv(rsp_bit), 0);
        rv_cnt = 0;
        repeat (7000) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rv_cnt++;
        end
        chk("abort_no_rsp", rv_cnt, 0);

        // Line stuck low.
`ifdef ONEWIRE_BUS_FAULT_EN
        exp_bf = 1;
`else
        exp_bf = 0;
`endif
        s_stuck = 1;
        do_slot(2'd3, 1'b0, 701, 0, 0);
        chk("stuck_fault_after_read", lv(bus_fault), exp_bf);
        do_slot(2'd2, 1'b0, 701, 0, 1);
        chk("stuck_fault_sticky", lv(bus_fault), exp_bf);
        s_stuck = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("fault_cleared", lv(bus_fault), 0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
